// File: rtl/cache_fill_controller.sv
// Direct-mapped cache tag/valid store with a miss-handling line-fill FSM.
// Hit/miss statistics counters are built only when CACHE_FILL_STATS_EN is defined.
module cache_fill_controller #(
    parameter int ADDRESS_WIDTH     = 10,
    parameter int MEM_ADDRESS_WIDTH = 16,
    parameter int OFFSET_WIDTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         proc_req,
    input  logic [MEM_ADDRESS_WIDTH-1:0] proc_addr,
    output logic                         proc_stall,
    output logic                         cache_select,
    output logic [ADDRESS_WIDTH-1:0]     fsm_address,
    output logic                         cache_we,
    output logic                         mem_rd_req,
    output logic [MEM_ADDRESS_WIDTH-1:0] mem_rd_addr,
    input  logic                         mem_rd_valid,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  miss_count
);

    localparam int INDEX_WIDTH = ADDRESS_WIDTH - OFFSET_WIDTH;
    localparam int TAG_WIDTH   = MEM_ADDRESS_WIDTH - ADDRESS_WIDTH;
    localparam int NUM_LINES   = 1 << INDEX_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = '1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_LINES-1:0]     valid_q, valid_d;
    logic [TAG_WIDTH-1:0]     tag_store_q [NUM_LINES];
    logic [INDEX_WIDTH-1:0]   index_q, index_d;
    logic [TAG_WIDTH-1:0]     tag_q, tag_d;
    logic [OFFSET_WIDTH-1:0]  count_q, count_d;

    logic [INDEX_WIDTH-1:0]   req_index;
    logic [TAG_WIDTH-1:0]     req_tag;
    logic                     hit;
    logic                     unused_offset;

    assign req_index     = proc_addr[ADDRESS_WIDTH-1:OFFSET_WIDTH];
    assign req_tag       = proc_addr[MEM_ADDRESS_WIDTH-1:ADDRESS_WIDTH];
    assign unused_offset = ^proc_addr[OFFSET_WIDTH-1:0];
    assign hit = proc_req && valid_q[req_index] && (tag_store_q[req_index] == req_tag);

    // Only control state is reset; the captured miss address and tag store are
    // qualified by the state and valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
        index_q <= index_d;
        tag_q   <= tag_d;
    end

    always_ff @(posedge clk) begin
        if (state_q == DONE) begin
            tag_store_q[index_q] <= tag_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        index_d      = index_q;
        tag_d        = tag_q;
        count_d      = count_q;
        proc_stall   = 1'b1;
        cache_select = 1'b0;
        fsm_address  = '0;
        cache_we     = 1'b0;
        mem_rd_req   = 1'b0;
        mem_rd_addr  = '0;
        case (state_q)
            IDLE: begin
                proc_stall = proc_req && !hit;
                if (proc_req && !hit) begin
                    index_d = req_index;
                    tag_d   = req_tag;
                    state_d = REQ;
                end
            end
            REQ: begin
                cache_select = 1'b1;
                mem_rd_req   = 1'b1;
                mem_rd_addr  = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
                count_d      = '0;
                state_d      = FILL;
            end
            FILL: begin
                cache_select = 1'b1;
                fsm_address  = {index_q, count_q};
                if (mem_rd_valid) begin
                    cache_we = 1'b1;
                    count_d  = count_q + OFFSET_WIDTH'(1);
                    if (count_q == LAST_WORD) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // The line only becomes valid once every word has been written.
                valid_d[index_q] = 1'b1;
                state_d          = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_FILL_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == IDLE && hit && hit_cnt_q != 16'hFFFF) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
        if (state_q == IDLE && proc_req && !hit && miss_cnt_q != 16'hFFFF) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
